edge_period_meter: RTL

Measures the period of a square wave captured by an 8:1 input deserializer, with 1/8-CLK-cycle edge resolution and averaging over 2^AVG_LOG2 periods. It sits after the ISERDES on the sensor input pin and produces fixed-point period values for the pitch/volume processing chain. It is the receive-side counterpart of the DDR NCO oscillator: a period programmed into the oscillator reads back here, in sample units.

---
 rtl/edge_period_meter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/edge_period_meter.sv
// Period meter for an 8:1 deserialized square wave: 1/8-cycle edge timestamps,
// sums of 2^AVG_LOG2 back-to-back periods, and loss-of-signal detection.
module edge_period_meter #(
  parameter int COUNTER_BITS = 16,
  parameter int AVG_LOG2     = 4,
  parameter int TIMEOUT_BITS = 12
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    CE,
  input  logic [7:0]              IN,
  output logic [COUNTER_BITS+2:0] PERIOD_OUT,
  output logic                    PERIOD_VALID,
  output logic                    SIGNAL_LOST
);

  localparam int TS_W = COUNTER_BITS + 3;
  localparam logic [AVG_LOG2-1:0]     EDGE_LAST = '1;
  localparam logic [TIMEOUT_BITS-1:0] TO_MAX    = '1;
  localparam logic [TIMEOUT_BITS-1:0] TO_PRE    = TO_MAX - 1'b1;

  typedef enum logic {WAIT_FIRST = 1'b0, MEASURE = 1'b1} state_t;

  state_t state_q, state_d;

  logic [7:0]              in_p1;
  logic                    prev_bit_p1;
  logic [COUNTER_BITS-1:0] cyc_cnt_p1;

  logic [7:0]              rise_p1;
  logic                    hit_p1;
  logic [TS_W-1:0]         ts_p1;
  logic                    step, quiet_step, to_fire;
  logic                    open_win, close_win;

  logic [AVG_LOG2-1:0]     edge_cnt_p2;
  logic [TS_W-1:0]         start_ts_p2;
  logic [TIMEOUT_BITS-1:0] timeout_cnt_p2;

  // Lowest set bit of the rise mask is the first rising edge in the word.
  function automatic logic [2:0] first_rise(input logic [7:0] r);
    logic [2:0] p;
    p = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r[i]) p = 3'(i);
    end
    return p;
  endfunction

  function automatic logic [TIMEOUT_BITS-1:0] sat_inc(input logic [TIMEOUT_BITS-1:0] v);
    return (v == TO_MAX) ? v : v + 1'b1;
  endfunction

  // ---- stage 1: word capture and word timestamp ----
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      in_p1       <= '0;
      prev_bit_p1 <= 1'b1;
      cyc_cnt_p1  <= '0;
    end else if (CE) begin
      in_p1       <= IN;
      prev_bit_p1 <= in_p1[7];
      cyc_cnt_p1  <= cyc_cnt_p1 + 1'b1;
    end
  end

  assign rise_p1    = in_p1 & ~{in_p1[6:0], prev_bit_p1};
  assign hit_p1     = |rise_p1;
  assign ts_p1      = {cyc_cnt_p1, first_rise(rise_p1)};
  assign step       = CE & hit_p1;
  assign quiet_step = CE & ~hit_p1;
  assign to_fire    = quiet_step & ((timeout_cnt_p2 == TO_MAX) | (timeout_cnt_p2 == TO_PRE));

  // ---- stage 2: window FSM and result registers ----
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= WAIT_FIRST;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_FIRST: if (step)    state_d = MEASURE;
      MEASURE:    if (to_fire) state_d = WAIT_FIRST;
      default:                 state_d = WAIT_FIRST;
    endcase
  end

  always_comb begin
    open_win  = 1'b0;
    close_win = 1'b0;
    case (state_q)
      WAIT_FIRST: open_win  = step;
      MEASURE:    close_win = step & (edge_cnt_p2 == EDGE_LAST);
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      edge_cnt_p2    <= '0;
      start_ts_p2    <= '0;
      timeout_cnt_p2 <= '0;
      PERIOD_OUT     <= '0;
      PERIOD_VALID   <= 1'b0;
      SIGNAL_LOST    <= 1'b0;
    end else begin
      PERIOD_VALID <= close_win;
      if (step) begin
        edge_cnt_p2    <= (open_win | close_win) ? '0 : edge_cnt_p2 + 1'b1;
        timeout_cnt_p2 <= '0;
        SIGNAL_LOST    <= 1'b0;
      end else if (quiet_step) begin
        timeout_cnt_p2 <= sat_inc(timeout_cnt_p2);
        if (to_fire) begin
          edge_cnt_p2 <= '0;
          SIGNAL_LOST <= 1'b1;
        end
      end
      if (open_win | close_win) start_ts_p2 <= ts_p1;
      // Modular subtraction keeps results correct across counter wrap.
      if (close_win) PERIOD_OUT <= ts_p1 - start_ts_p2;
    end
  end

endmodule
